jtag_dbg_dr: RTL and testbench
==============================

Name: jtag_dbg_dr

Overview:
- User data register hung off the JTAG TAP's DR path. Selected when the IR holds the debug-access opcode.
- Shifts a command word in on TDI and returns status and read data on TDO.
- On Update-DR, launches a single read or write on a 4-phase req/ack port toward the debug bus bridge.
- Lives entirely in the TCK domain; any CDC belongs to the bridge, not this block.

Parameters:
- ADDR_W, 16, debug bus address width (>=2).
- DATA_W, 32, debug bus data width.
- SR_W, 2+ADDR_W+DATA_W, derived shift-register width; not overridable.

Ports:
- tck  in  1  test clock; all state updates on rising edge.
- trst_n  in  1  asynchronous active-low reset.
- tdi  in  1  serial data in.
- dr_sel  in  1  IR decode: this DR is selected.
- tap_reset  in  1  TAP in Test-Logic-Reset.
- tap_capture_dr  in  1  TAP in Capture-DR.
- tap_shift_dr  in  1  TAP in Shift-DR.
- tap_update_dr  in  1  TAP in Update-DR.
- dr_tdo  out  1  serial out; the TAP retimes it on the falling edge.
- req  out  1  bus request (4-phase).
- req_we  out  1  1 = write, 0 = read.
- req_addr  out  ADDR_W  bus address.
- req_wdata  out  DATA_W  write data.
- ack  in  1  bus acknowledge (4-phase).
- ack_rdata  in  DATA_W  read data; valid while ack=1.
- ack_err  in  1  bus error; valid while ack=1.

Behaviour:
- Shift-register layout (LSB shifted first): sr[1:0]=op, sr[ADDR_W+1:2]=addr, sr[SR_W-1:ADDR_W+2]=data.
- Op encoding: 00 NOP, 01 READ, 10 WRITE, 11 CLEAR_STATUS.
- dr_tdo = sr[0], combinational.
- Capture (tap_capture_dr & dr_sel): sr[0]<=busy, sr[1]<=err_sticky, addr field<=last issued addr, data field<=rdata_q.
- Shift (tap_shift_dr & dr_sel): sr <= {tdi, sr[SR_W-1:1]}.
- Without dr_sel, sr holds its value.
- Update (tap_update_dr & dr_sel), sampled at the rising edge:
  - NOP: no effect.
  - CLEAR_STATUS: err_sticky<=0, permitted in any FSM state.
  - READ/WRITE in IDLE: latch req_addr, req_we, and req_wdata (write only); FSM -> REQ; req=1 from that same edge.
  - READ/WRITE while busy: command dropped, err_sticky<=1 (overrun).
- FSM states: IDLE, REQ, DONE.
  - IDLE -> REQ: on accepted command.
  - REQ -> DONE: on ack=1. At that edge req<=0, err_sticky |= ack_err, and for a read rdata_q<=ack_rdata.
  - DONE -> IDLE: on ack=0.
  - busy = (state != IDLE).
- req_addr, req_we and req_wdata stay stable from req rise until ack is seen high.
- Latency: req rises 1 tck after the Update-DR edge; it falls on the edge where ack is first sampled high.
- An ack arriving in IDLE is ignored.
- tap_reset=1: sr<=0, err_sticky<=0.
  - An in-flight handshake is not aborted; it completes to protect the bridge.
  - rdata_q is retained.
- trst_n=0 (async): state=IDLE, req=0, req_we=0, req_addr=0, req_wdata=0, sr=0, rdata_q=0, err_sticky=0; hence dr_tdo=0.
- Simultaneous CLEAR_STATUS update and ack with ack_err: set wins, err_sticky=1.
- Capture while busy: reports busy=1; the data field returns the stale rdata_q.

Decomposition:
- Package jtag_pkg:
  - op encodings OP_NOP/OP_READ/OP_WRITE/OP_CLEAR.
  - FSM state localparams.
  - the debug-access IR opcode (4'b1000), used by the IR decode feeding dr_sel.
- No sub-module: shift register, command decode and handshake FSM live in one module.

Test Plan:
- trst_n pulse mid-handshake (req=1) -> req, req_addr and dr_tdo go 0 immediately; the following capture shifts out all zeros.
- WRITE, addr 16'h0040, data 32'hDEAD_BEEF:
  - req=1 with req_we=1, req_addr=16'h0040, req_wdata=32'hDEADBEEF one tck after Update-DR.
  - ack held 3 cycles then low -> FSM returns to IDLE; the next capture shows busy=0, err=0.
- READ addr 16'h0010, bridge returns ack_rdata=32'h1234_5678 -> the next DR scan shifts out status 2'b00, addr 16'h0010, data 32'h12345678, LSB first.
- Second WRITE while ack withheld:
  - command ignored; req_addr stays at the first value.
  - the next capture shows busy=1, err=1.
  - after CLEAR_STATUS and handshake completion, the capture shows 2'b00.
- Read with ack_err=1 -> err_sticky=1 and rdata_q=ack_rdata; TMS high 5 cycles (tap_reset) -> the following capture shows err=0.
- dr_sel=0 with shift/update pulses and a WRITE pattern -> no req, sr unchanged, dr_tdo constant.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared encodings for the JTAG debug-access data register.
// Command op codes, handshake FSM states and the IR opcode that selects this DR.
package jtag_pkg;

   localparam logic [1:0] OP_NOP   = 2'b00;
   localparam logic [1:0] OP_READ  = 2'b01;
   localparam logic [1:0] OP_WRITE = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   typedef logic [1:0] dbg_state_t;
   localparam dbg_state_t ST_IDLE = 2'd0;
   localparam dbg_state_t ST_REQ  = 2'd1;
   localparam dbg_state_t ST_DONE = 2'd2;

   localparam logic [3:0] IR_DBG_ACCESS = 4'b1000;

endpackage

// File: rtl/jtag_dbg_dr.sv
// Debug-access JTAG data register: serial command/status shifter plus a
// single-outstanding 4-phase req/ack launcher toward the debug bus bridge.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no transfer outstanding, a READ/WRITE update is accepted
// REQ     | req high, address/we/wdata held, waiting for ack high
// DONE    | ack seen and req dropped, waiting for the bridge to drop ack
module jtag_dbg_dr
   import jtag_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
) (
   input  logic              tck,
   input  logic              trst_n,
   input  logic              tdi,
   input  logic              dr_sel,
   input  logic              tap_reset,
   input  logic              tap_capture_dr,
   input  logic              tap_shift_dr,
   input  logic              tap_update_dr,
   output logic              dr_tdo,
   output logic              req,
   output logic              req_we,
   output logic [ADDR_W-1:0] req_addr,
   output logic [DATA_W-1:0] req_wdata,
   input  logic              ack,
   input  logic [DATA_W-1:0] ack_rdata,
   input  logic              ack_err
);

   localparam int SR_W = 2 + ADDR_W + DATA_W;

   dbg_state_t        state_q, state_d;
   logic [SR_W-1:0]   sr_q, sr_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              req_we_q, req_we_d;
   logic [ADDR_W-1:0] req_addr_q, req_addr_d;
   logic [DATA_W-1:0] req_wdata_q, req_wdata_d;

   logic [1:0] cmd_op;
   logic       upd_en;
   logic       cmd_rw;
   logic       accept;
   logic       ack_done;
   logic       busy;

   assign cmd_op   = sr_q[1:0];
   assign upd_en   = tap_update_dr & dr_sel;
   assign cmd_rw   = upd_en & ((cmd_op == OP_READ) | (cmd_op == OP_WRITE));
   assign accept   = cmd_rw & (state_q == ST_IDLE);
   assign ack_done = (state_q == ST_REQ) & ack;

   always_ff @(posedge tck or negedge trst_n) begin
      if (!trst_n) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // tap_reset deliberately has no say here: an in-flight handshake always completes.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = ST_REQ;
         ST_REQ:  if (ack)    state_d = ST_DONE;
         ST_DONE: if (!ack)   state_d = ST_IDLE;
         default:             state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      req  = (state_q == ST_REQ);
      busy = (state_q != ST_IDLE);
   end

   always_comb begin
      sr_d = sr_q;
      if (tap_reset)
         sr_d = '0;
      else if (tap_capture_dr & dr_sel)
         sr_d = {rdata_q, req_addr_q, err_q, busy};
      else if (tap_shift_dr & dr_sel)
         sr_d = {tdi, sr_q[SR_W-1:1]};

      // Clears first, sets last: a bus error or overrun landing on the same edge wins.
      err_d = err_q;
      if (tap_reset || (upd_en && (cmd_op == OP_CLEAR))) err_d = 1'b0;
      if (cmd_rw && busy)                                 err_d = 1'b1;
      if (ack_done && ack_err)                            err_d = 1'b1;

      req_we_d    = req_we_q;
      req_addr_d  = req_addr_q;
      req_wdata_d = req_wdata_q;
      if (accept) begin
         req_we_d   = (cmd_op == OP_WRITE);
         req_addr_d = sr_q[ADDR_W+1:2];
         if (cmd_op == OP_WRITE) req_wdata_d = sr_q[SR_W-1:ADDR_W+2];
      end

      rdata_d = rdata_q;
      if (ack_done && !req_we_q) rdata_d = ack_rdata;
   end

   always_ff @(posedge tck or negedge trst_n) begin
      if (!trst_n) begin
         sr_q        <= '0;
         err_q       <= 1'b0;
         rdata_q     <= '0;
         req_we_q    <= 1'b0;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
      end else begin
         sr_q        <= sr_d;
         err_q       <= err_d;
         rdata_q     <= rdata_d;
         req_we_q    <= req_we_d;
         req_addr_q  <= req_addr_d;
         req_wdata_q <= req_wdata_d;
      end
   end

   assign dr_tdo    = sr_q[0];
   assign req_we    = req_we_q;
   assign req_addr  = req_addr_q;
   assign req_wdata = req_wdata_q;

endmodule

// File: tb/tb_jtag_dbg_dr.sv
// Bench for jtag_dbg_dr: directed scenarios plus random command/handshake mix
// checked against a transaction-level model of the DR status and bus port.
module tb_jtag_dbg_dr;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 32;
   localparam int SR_W   = 2 + ADDR_W + DATA_W;

   localparam logic [1:0] C_NOP   = 2'b00;
   localparam logic [1:0] C_READ  = 2'b01;
   localparam logic [1:0] C_WRITE = 2'b10;
   localparam logic [1:0] C_CLEAR = 2'b11;

   logic              tck = 1'b0;
   logic              trst_n;
   logic              tdi;
   logic              dr_sel;
   logic              tap_reset;
   logic              tap_capture_dr;
   logic              tap_shift_dr;
   logic              tap_update_dr;
   logic              dr_tdo;
   logic              req;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              ack;
   logic [DATA_W-1:0] ack_rdata;
   logic              ack_err;

   jtag_dbg_dr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .tck            (tck),
      .trst_n         (trst_n),
      .tdi            (tdi),
      .dr_sel         (dr_sel),
      .tap_reset      (tap_reset),
      .tap_capture_dr (tap_capture_dr),
      .tap_shift_dr   (tap_shift_dr),
      .tap_update_dr  (tap_update_dr),
      .dr_tdo         (dr_tdo),
      .req            (req),
      .req_we         (req_we),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .ack            (ack),
      .ack_rdata      (ack_rdata),
      .ack_err        (ack_err)
   );

   always #5 tck = ~tck;

   int n_chk = 0;
   int n_err = 0;

   // Model: what the bridge-facing port and captured status should look like.
   logic              m_busy;
   logic              m_err;
   logic [ADDR_W-1:0] m_addr;
   logic              m_we;
   logic [DATA_W-1:0] m_wdata;
   logic [DATA_W-1:0] m_rdata;
   logic              m_tdo;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] exp_cap();
      return {14'd0, m_rdata, m_addr, m_err, m_busy};
   endfunction

   task automatic model_reset();
      m_busy = 0; m_err = 0; m_addr = '0; m_we = 0;
      m_wdata = '0; m_rdata = '0; m_tdo = 0;
   endtask

   task automatic check_port(input string tag);
      chk({tag, " req"},       req,       m_busy);
      chk({tag, " req_we"},    req_we,    m_we);
      chk({tag, " req_addr"},  req_addr,  m_addr);
      chk({tag, " req_wdata"}, req_wdata, m_wdata);
   endtask

   // Full DR scan: capture, shift SR_W bits, update. Optionally the bridge
   // acks (with error) on the very edge the update is sampled.
   task automatic scan(input logic [1:0] op, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input string tag, input bit co_ack);
      logic [SR_W-1:0] din;
      logic [SR_W-1:0] dout;
      din = {d, a, op};
      @(negedge tck);
      dr_sel = 1; tap_capture_dr = 1;
      @(negedge tck);
      tap_capture_dr = 0; tap_shift_dr = 1;
      for (int i = 0; i < SR_W; i++) begin
         dout[i] = dr_tdo;
         tdi = din[i];
         @(negedge tck);
      end
      tap_shift_dr = 0; tap_update_dr = 1;
      chk({tag, " capture"}, dout, exp_cap());
      if (co_ack) begin
         ack = 1; ack_err = 1; ack_rdata = 32'hCAFE_F00D;
      end
      @(negedge tck);
      tap_update_dr = 0;
      m_tdo = op[0];
      case (op)
         C_CLEAR: m_err = 0;
         C_READ, C_WRITE: begin
            if (m_busy) m_err = 1;
            else begin
               m_busy = 1; m_addr = a; m_we = (op == C_WRITE);
               if (op == C_WRITE) m_wdata = d;
            end
         end
         default: ;
      endcase
      if (co_ack) begin
         m_err = 1;
         if (!m_we) m_rdata = 32'hCAFE_F00D;
         chk({tag, " co-ack req drop"}, req, 0);
         ack = 0; ack_err = 0;
         @(negedge tck);
         m_busy = 0;
      end
      check_port(tag);
   endtask

   task automatic handshake(input logic [DATA_W-1:0] rd, input logic er, input int hold,
                            input string tag);
      int t;
      t = 0;
      while (!req && t < 20) begin
         @(negedge tck);
         t++;
      end
      chk({tag, " req seen"}, req, 1);
      chk({tag, " hs we"},    req_we,    m_we);
      chk({tag, " hs addr"},  req_addr,  m_addr);
      chk({tag, " hs wdata"}, req_wdata, m_wdata);
      ack = 1; ack_rdata = rd; ack_err = er;
      @(negedge tck);
      chk({tag, " req fall"}, req, 0);
      chk({tag, " addr held"}, req_addr, m_addr);
      for (int i = 1; i < hold; i++) @(negedge tck);
      ack = 0; ack_err = 0; ack_rdata = $urandom;
      @(negedge tck);
      if (er) m_err = 1;
      if (!m_we) m_rdata = rd;
      m_busy = 0;
   endtask

   task automatic tlr(input int cycles);
      @(negedge tck);
      tap_reset = 1;
      for (int i = 0; i < cycles; i++) @(negedge tck);
      tap_reset = 0;
      m_err = 0; m_tdo = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected done");
      $fatal(1);
   end

   initial begin
      logic [1:0]        op;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;

      trst_n = 0; tdi = 0; dr_sel = 0; tap_reset = 0; tap_capture_dr = 0;
      tap_shift_dr = 0; tap_update_dr = 0; ack = 0; ack_rdata = '0; ack_err = 0;
      model_reset();
      repeat (3) @(negedge tck);
      chk("rst dr_tdo", dr_tdo, 0);
      check_port("rst");
      trst_n = 1;
      @(negedge tck);

      scan(C_WRITE, 16'h0040, 32'hDEAD_BEEF, "wr0040", 0);
      handshake(32'h0, 0, 3, "wr0040");
      scan(C_NOP, 16'h0, 32'h0, "post wr", 0);

      scan(C_READ, 16'h0010, 32'h0, "rd0010", 0);
      handshake(32'h1234_5678, 0, 2, "rd0010");
      scan(C_NOP, 16'h0, 32'h0, "post rd", 0);
      chk("rd data seen", m_rdata, 32'h1234_5678);

      scan(C_WRITE, 16'h0100, 32'h1111_2222, "ovr first", 0);
      scan(C_WRITE, 16'h0200, 32'h3333_4444, "ovr second", 0);
      scan(C_CLEAR, 16'h0, 32'h0, "ovr clear", 0);
      handshake(32'h0, 0, 1, "ovr");
      scan(C_NOP, 16'h0, 32'h0, "post ovr", 0);

      scan(C_READ, 16'h0BAD, 32'h0, "rderr", 0);
      handshake(32'hA5A5_5A5A, 1, 2, "rderr");
      scan(C_NOP, 16'h0, 32'h0, "post rderr", 0);
      tlr(5);
      chk("tlr dr_tdo", dr_tdo, 0);
      scan(C_NOP, 16'h0, 32'h0, "post tlr", 0);

      scan(C_READ, 16'h0777, 32'h0, "tlr inflight", 0);
      tlr(5);
      chk("tlr inflight req", req, 1);
      handshake(32'h0F0F_0F0F, 0, 2, "tlr inflight");

      scan(C_READ, 16'h0123, 32'h0, "coack rd", 0);
      scan(C_CLEAR, 16'h0, 32'h0, "coack clr", 1);
      scan(C_NOP, 16'h0, 32'h0, "post coack", 0);

      scan(C_NOP, 16'h0055, 32'h0, "pre unsel", 0);
      @(negedge tck);
      dr_sel = 0; tap_capture_dr = 1;
      @(negedge tck);
      tap_capture_dr = 0; tap_shift_dr = 1;
      for (int i = 0; i < 12; i++) begin
         tdi = (i % 3 == 0) ? 1'b0 : 1'b1;
         @(negedge tck);
         chk("unsel dr_tdo", dr_tdo, m_tdo);
      end
      tap_shift_dr = 0; tap_update_dr = 1;
      @(negedge tck);
      tap_update_dr = 0;
      @(negedge tck);
      chk("unsel dr_tdo end", dr_tdo, m_tdo);
      check_port("unsel");

      scan(C_WRITE, 16'h0ABC, 32'h5555_AAAA, "trst wr", 0);
      @(negedge tck);
      trst_n = 0;
      #1;
      chk("trst req", req, 0);
      chk("trst req_addr", req_addr, 0);
      chk("trst dr_tdo", dr_tdo, 0);
      #2 trst_n = 1;
      model_reset();
      scan(C_NOP, 16'h0, 32'h0, "post trst", 0);

      for (int it = 0; it < 40; it++) begin
         op = 2'($urandom_range(0, 3));
         a  = 16'($urandom);
         d  = $urandom;
         scan(op, a, d, "rnd", 0);
         if (m_busy) begin
            if ($urandom_range(0, 1) == 1)
               scan(2'($urandom_range(0, 3)), 16'($urandom), $urandom, "rnd busy", 0);
            handshake($urandom, ($urandom_range(0, 3) == 0), int'($urandom_range(1, 4)), "rnd");
         end
      end
      scan(C_NOP, 16'h0, 32'h0, "final", 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
